st_wide_to_narrow_adapter: RTL and testbench
============================================

Name: st_wide_to_narrow_adapter

Overview:
- Avalon-ST width-down adapter on the read side of the mSGDMA 128-bit datapath.
- Accepts wide packet words from the timing adapter FIFO output, with sop, eop and empty.
- Serialises each word into 32-bit beats for a narrow sink (CSR/stream peripheral), first symbol in MSBs.
- Full throughput: one narrow beat per cycle, no bubble between consecutive wide words.

Parameters:
- IN_WIDTH, 128, wide data width in bits.
- OUT_WIDTH, 32, narrow data width in bits.
- SYMBOL_WIDTH, 8, bits per symbol.
- Derived, not overridable: IN_SYMS=16, OUT_SYMS=4, LANES=IN_WIDTH/OUT_WIDTH=4, LANE_W=2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_ready  out  1  sink ready, ready latency 0
- in_valid  in  1  wide word valid
- in_data  in  128  wide data, symbol 0 in [127:120]
- in_sop  in  1  start of packet
- in_eop  in  1  end of packet
- in_empty  in  4  unused symbols in eop word; ignored unless in_eop
- out_ready  in  1  narrow sink ready, ready latency 0
- out_valid  out  1  narrow beat valid
- out_data  out  32  narrow data, first symbol in [31:24]
- out_sop  out  1  first beat of packet
- out_eop  out  1  last beat of packet
- out_empty  out  2  unused symbols in eop beat

Behaviour:
- Reset (async assert, sync deassert) drives out_valid=0, out_data=0, out_sop=0, out_eop=0, out_empty=0, in_ready=1, lane=0, state=IDLE.
- Holding register hold_data[127:0], hold_sop, hold_eop, last_lane[1:0], hold_oempty[1:0].
- States:
  - IDLE: no word held.
  - SHIFT: word held; lane counter 0..last_lane.
- Definitions:
  - Accept = in_valid && in_ready.
  - Beat = out_valid && out_ready.
  - final_beat = (lane==last_lane).
- in_ready rule, combinational: in_ready = (state==IDLE) || (Beat && final_beat). Bubble-free reload.
- On Accept:
  - Latch word.
  - last_lane = in_eop ? 3-(in_empty>>2) : 3.
  - hold_oempty = in_eop ? in_empty[1:0] : 0.
  - lane=0; state=SHIFT.
- Outputs are registered, reflecting the current lane:
  - out_data = hold_data[127-32*lane -: 32].
  - out_sop = hold_sop && lane==0.
  - out_eop = hold_eop && final_beat.
  - out_empty = final_beat && hold_eop ? hold_oempty : 0.
- Latency: a word accepted at edge N presents lane 0 after edge N; out_valid=1 in the cycle following N.
- SHIFT transitions:
  - Beat && !final_beat: lane+1.
  - Beat && final_beat && Accept: reload, lane=0, stay SHIFT.
  - Beat && final_beat && !Accept: IDLE, out_valid=0.
  - !Beat: hold everything; out_* stable while out_valid && !out_ready.
- Short eop word: in_empty=12..15 gives last_lane=0, so 1 beat. Example: in_empty=15 gives out_empty=3.
- Non-eop word with in_empty≠0: in_empty is ignored and all 4 beats are emitted.
- Packet framing is not checked. A missing sop/eop passes through unchanged.
- Reset mid-word: the held data is discarded and no partial beat is emitted after release.

Optional Feature:
- ST_W2N_ERROR_EN adds port in_error (in, 1) and port out_error (out, 1).
- With the macro: in_error is latched on Accept, and out_error equals the latched bit on every beat of that word. out_error resets to 0.
- Without the macro: the ports are absent and no error logic is present.

Test Plan:
- Reset, then one word 0x00112233_44556677_8899AABB_CCDDEEFF with sop=1, eop=1, empty=0, out_ready=1:
  - Beats 0x00112233 (sop), 0x44556677, 0x8899AABB, 0xCCDDEEFF (eop, empty=0).
  - Exactly 4 cycles of out_valid.
- Two back-to-back words, in_valid held high, out_ready=1:
  - in_ready pulses high once per 4 cycles.
  - 8 consecutive beats with no out_valid gap.
  - sop on beat 0 only; eop on beat 7 only.
- eop word with empty=6:
  - 3 beats; last beat has eop=1 and out_empty=2.
  - Repeat with empty=15: 1 beat with sop=1, eop=1, out_empty=3.
- out_ready toggled 1,0,0,1,1,0,1,1:
  - out_data/sop/eop/empty stable during stalls.
  - Exactly 4 beats in order; in_ready stays 0 until the final beat is accepted.
- reset_n asserted after lane 1 of a 4-beat word, then released:
  - out_valid=0 immediately and remains 0 until the next accepted word.
  - That word starts at lane 0 with sop.
- ST_W2N_ERROR_EN defined, word with in_error=1 followed by word with in_error=0:
  - out_error=1 on beats 0-3 and 0 on beats 4-7.

Source files
------------

// File: rtl/st_wide_to_narrow_adapter.sv
// ============================================================================
// Module   : st_wide_to_narrow_adapter
// Brief    : Avalon-ST width-down adapter, wide packet words to narrow beats,
//            first symbol in MSBs. Optional macro: ST_W2N_ERROR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module st_wide_to_narrow_adapter #(
  parameter  int IN_WIDTH     = 128,
  parameter  int OUT_WIDTH    = 32,
  parameter  int SYMBOL_WIDTH = 8,
  localparam int IN_SYMS      = IN_WIDTH / SYMBOL_WIDTH,
  localparam int OUT_SYMS     = OUT_WIDTH / SYMBOL_WIDTH,
  localparam int LANES        = IN_WIDTH / OUT_WIDTH,
  localparam int LANE_W       = $clog2(LANES),
  localparam int IN_EMPTY_W   = $clog2(IN_SYMS),
  localparam int OUT_EMPTY_W  = $clog2(OUT_SYMS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [IN_EMPTY_W-1:0]  in_empty,
`ifdef ST_W2N_ERROR_EN
  input  logic                   in_error,
  output logic                   out_error,
`endif
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [OUT_EMPTY_W-1:0] out_empty
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                 state, n_state;
  logic [IN_WIDTH-1:0]    hold_data, n_hold_data;
  logic                   hold_sop, n_hold_sop;
  logic                   hold_eop, n_hold_eop;
  logic [LANE_W-1:0]      last_lane, n_last_lane;
  logic [OUT_EMPTY_W-1:0] hold_oempty, n_hold_oempty;
  logic [LANE_W-1:0]      lane, n_lane;
`ifdef ST_W2N_ERROR_EN
  logic                   hold_error, n_hold_error;
`endif

  logic                   beat, final_beat, accept, n_final;
  logic [IN_WIDTH-1:0]    shifted;

  always_comb begin
    beat       = out_valid && out_ready;
    final_beat = (lane == last_lane);
    in_ready   = (state == IDLE) || (beat && final_beat);
    accept     = in_valid && in_ready;

    n_state       = state;
    n_hold_data   = hold_data;
    n_hold_sop    = hold_sop;
    n_hold_eop    = hold_eop;
    n_last_lane   = last_lane;
    n_hold_oempty = hold_oempty;
    n_lane        = lane;
`ifdef ST_W2N_ERROR_EN
    n_hold_error  = hold_error;
`endif

    if (beat) begin
      if (final_beat) n_state = IDLE;
      else            n_lane  = lane + 1'b1;
    end

    // A reload on the final beat overrides the IDLE transition above.
    if (accept) begin
      n_state       = SHIFT;
      n_hold_data   = in_data;
      n_hold_sop    = in_sop;
      n_hold_eop    = in_eop;
      n_lane        = '0;
      n_last_lane   = in_eop ? LANE_W'((IN_SYMS - 1 - int'(in_empty)) / OUT_SYMS)
                             : LANE_W'(LANES - 1);
      n_hold_oempty = in_eop ? in_empty[OUT_EMPTY_W-1:0] : '0;
`ifdef ST_W2N_ERROR_EN
      n_hold_error  = in_error;
`endif
    end

    n_final = (n_lane == n_last_lane);
    shifted = n_hold_data << (OUT_WIDTH * int'(n_lane));
  end

  // Outputs are registered from next-state values so they describe the lane held after the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hold_data   <= '0;
      hold_sop    <= 1'b0;
      hold_eop    <= 1'b0;
      last_lane   <= '0;
      hold_oempty <= '0;
      lane        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_empty   <= '0;
`ifdef ST_W2N_ERROR_EN
      hold_error  <= 1'b0;
      out_error   <= 1'b0;
`endif
    end else begin
      state       <= n_state;
      hold_data   <= n_hold_data;
      hold_sop    <= n_hold_sop;
      hold_eop    <= n_hold_eop;
      last_lane   <= n_last_lane;
      hold_oempty <= n_hold_oempty;
      lane        <= n_lane;
      out_valid   <= (n_state == SHIFT);
      out_data    <= shifted[IN_WIDTH-1 -: OUT_WIDTH];
      out_sop     <= (n_state == SHIFT) && n_hold_sop && (n_lane == '0);
      out_eop     <= (n_state == SHIFT) && n_hold_eop && n_final;
      out_empty   <= ((n_state == SHIFT) && n_hold_eop && n_final) ? n_hold_oempty : '0;
`ifdef ST_W2N_ERROR_EN
      hold_error  <= n_hold_error;
      out_error   <= (n_state == SHIFT) && n_hold_error;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_st_wide_to_narrow_adapter.sv
// ============================================================================
// Module   : tb_st_wide_to_narrow_adapter
// Brief    : Directed, table-driven bench for st_wide_to_narrow_adapter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_st_wide_to_narrow_adapter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_ready;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_sop = 1'b0;
  logic         in_eop = 1'b0;
  logic [3:0]   in_empty = '0;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_sop;
  logic         out_eop;
  logic [1:0]   out_empty;
`ifdef ST_W2N_ERROR_EN
  logic         in_error = 1'b0;
  logic         out_error;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  st_wide_to_narrow_adapter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_ready  (in_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_empty  (in_empty),
`ifdef ST_W2N_ERROR_EN
    .in_error  (in_error),
    .out_error (out_error),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_empty (out_empty)
  );

  typedef struct {
    logic [127:0]      data;
    logic              sop;
    logic              eop;
    logic [3:0]        empty;
    int                n;
    logic [0:3][31:0]  beats;
    logic [1:0]        oempty;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [127:0] d, input logic s, input logic e,
                              input logic [3:0] em, input int n,
                              input logic [0:3][31:0] b, input logic [1:0] oe);
    vec_t v;
    v.data = d; v.sop = s; v.eop = e; v.empty = em; v.n = n; v.beats = b; v.oempty = oe;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    bit got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s: in_ready never rose", name);
    end
  endtask

  task automatic run_word(input vec_t v, input string name);
    int cnt = 0;
    @(posedge clk); #1;
    in_data = v.data; in_sop = v.sop; in_eop = v.eop; in_empty = v.empty; in_valid = 1'b1;
    wait_ready(name);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (cnt < 4) begin
          chk({name, " data"}, out_data, v.beats[cnt]);
          chk({name, " sop"}, out_sop, v.sop && cnt == 0);
          chk({name, " eop"}, out_eop, v.eop && cnt == v.n - 1);
          chk({name, " empty"}, out_empty, (v.eop && cnt == v.n - 1) ? v.oempty : 2'd0);
        end
        cnt++;
      end else if (cnt > 0) break;
    end
    chk({name, " beat count"}, cnt, v.n);
  endtask

  logic [31:0] exp8 [8] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
                            32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0};
  bit stall_pat [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected done");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(128'h00112233_44556677_8899AABB_CCDDEEFF, 1, 1, 4'd0, 4,
                 {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF}, 2'd0);
    vecs[1] = mk(128'h01234567_89ABCDEF_FEDCBA98_76543210, 1, 1, 4'd6, 3,
                 {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h0}, 2'd2);
    vecs[2] = mk(128'hA1B2C3D4_11111111_22222222_33333333, 1, 1, 4'd15, 1,
                 {32'hA1B2C3D4, 32'h0, 32'h0, 32'h0}, 2'd3);
    vecs[3] = mk(128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 0, 4'd9, 4,
                 {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}, 2'd0);
    vecs[4] = mk(128'h55AA55AA_66666666_77777777_88888888, 0, 1, 4'd12, 1,
                 {32'h55AA55AA, 32'h0, 32'h0, 32'h0}, 2'd0);
    vecs[5] = mk(128'h10203040_50607080_90A0B0C0_D0E0F000, 0, 1, 4'd4, 3,
                 {32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'h0}, 2'd0);

    // Reset state
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_sop", out_sop, 0);
    chk("reset out_eop", out_eop, 0);
    chk("reset out_empty", out_empty, 0);
    chk("reset in_ready", in_ready, 1);
    @(posedge clk); #1 reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_word(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back words with in_valid held high
    begin
      int acc = 0, beats = 0, gap = 0, irdy = 0;
      bit a;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_data = 128'h00112233_44556677_8899AABB_CCDDEEFF; in_sop = 1; in_eop = 0; in_empty = 0;
`ifdef ST_W2N_ERROR_EN
      in_error = 1'b1;
`endif
      in_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        a = in_valid && in_ready;
        if (out_valid) begin
          if (beats < 8) begin
            chk($sformatf("b2b data%0d", beats), out_data, exp8[beats]);
            chk($sformatf("b2b sop%0d", beats), out_sop, beats == 0);
            chk($sformatf("b2b eop%0d", beats), out_eop, beats == 7);
`ifdef ST_W2N_ERROR_EN
            chk($sformatf("b2b error%0d", beats), out_error, beats < 4);
`endif
          end
          if (in_ready) irdy++;
          beats++;
        end else if (beats > 0 && beats < 8) gap++;
        @(posedge clk); #1;
        if (a) begin
          acc++;
          if (acc == 1) begin
            in_data = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0; in_sop = 0; in_eop = 1; in_empty = 0;
`ifdef ST_W2N_ERROR_EN
            in_error = 1'b0;
`endif
          end else in_valid = 1'b0;
        end
      end
      chk("b2b beats", beats, 8);
      chk("b2b gaps", gap, 0);
      chk("b2b in_ready pulses", irdy, 2);
      chk("b2b accepts", acc, 2);
    end

    // Stall pattern on out_ready
    begin
      int beats = 0;
      logic [31:0] pd; logic ps, pe; logic [1:0] pm; bit stalled = 0;
      @(posedge clk); #1;
      in_data = vecs[0].data; in_sop = 1; in_eop = 1; in_empty = 0; in_valid = 1'b1;
      wait_ready("stall");
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = stall_pat[0];
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (stalled) begin
          chk($sformatf("stall hold data c%0d", i), out_data, pd);
          chk($sformatf("stall hold sop c%0d", i), out_sop, ps);
          chk($sformatf("stall hold eop c%0d", i), out_eop, pe);
          chk($sformatf("stall hold empty c%0d", i), out_empty, pm);
        end
        chk($sformatf("stall in_ready c%0d", i), in_ready,
            !out_valid || (out_ready && beats == 3));
        if (out_valid && out_ready) begin
          if (beats < 4) chk($sformatf("stall data%0d", beats), out_data, exp8[beats]);
          beats++;
        end
        stalled = out_valid && !out_ready;
        pd = out_data; ps = out_sop; pe = out_eop; pm = out_empty;
        @(posedge clk); #1;
        out_ready = stall_pat[i+1];
      end
      chk("stall beats", beats, 4);
      out_ready = 1'b1;
    end

    // Reset in the middle of a word
    @(posedge clk); #1;
    in_data = vecs[3].data; in_sop = 1; in_eop = 1; in_empty = 0; in_valid = 1'b1;
    wait_ready("midreset");
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midreset lane0 data", out_data, 32'h0F0E0D0C);
    @(negedge clk);
    chk("midreset lane1 data", out_data, 32'h0B0A0908);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midreset out_valid async", out_valid, 0);
    chk("midreset in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset idle %0d", i), out_valid, 0);
    end
    run_word(vecs[0], "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
